// File: rtl/mac_sequencer_pkg.sv
// Shared widths, state encoding and saturation limits for the FIR MAC sequencer.
package mac_sequencer_pkg;

  localparam int N    = 25;
  localparam int F    = 10;
  localparam int TAPS = 5;
  localparam int IDXW = $clog2(TAPS);

  typedef logic signed [N-1:0]   sample_t;
  typedef logic signed [2*N-1:0] wide_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam sample_t SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/mac_sequencer_if.sv
// Sample input, coefficient table, adder stage and result handshake of the MAC sequencer.
interface mac_sequencer_if;
  import mac_sequencer_pkg::*;

  logic            in_valid;
  logic            in_ready;
  sample_t         x_in;
  logic [IDXW-1:0] coef_idx;
  sample_t         coef_in;
  sample_t         mac_a;
  sample_t         mac_b;
  wide_t           mac_acc;
  wide_t           mac_sum;
  sample_t         y_out;
  logic            y_valid;
  logic            y_ready;
  logic            sat_flag;

  modport master (
    input  in_valid, x_in, coef_in, mac_sum, y_ready,
    output in_ready, coef_idx, mac_a, mac_b, mac_acc, y_out, y_valid, sat_flag
  );

  modport slave (
    output in_valid, x_in, coef_in, mac_sum, y_ready,
    input  in_ready, coef_idx, mac_a, mac_b, mac_acc, y_out, y_valid, sat_flag
  );

endinterface

// File: rtl/mac_sequencer_sat_trunc.sv
// Narrows a 2N-bit adder result to N bits: arithmetic shift right by F, then clip.
module mac_sequencer_sat_trunc
  import mac_sequencer_pkg::*;
(
  input  wide_t   x_i,
  output sample_t y_o,
  output logic    sat_o
);

  localparam wide_t W_MAX = wide_t'(SAT_MAX);
  localparam wide_t W_MIN = wide_t'(SAT_MIN);

  wide_t s;

  assign s = x_i >>> F;

  always_comb begin
    y_o   = s[N-1:0];
    sat_o = 1'b0;
    if (s > W_MAX) begin
      y_o   = SAT_MAX;
      sat_o = 1'b1;
    end else if (s < W_MIN) begin
      y_o   = SAT_MIN;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Sequential FIR controller driving an external combinational multiply-add stage.
// state  | meaning
// IDLE   | waiting for a sample; in_ready high
// ACCUM  | one tap per cycle, acc <= mac_sum
// OUTPUT | y_out held valid until y_ready
module mac_sequencer
  import mac_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  mac_sequencer_if.master bus
);

  logic [1:0]      state_q, state_d;
  sample_t         delay_q [TAPS];
  wide_t           acc_q, acc_d;
  logic [IDXW-1:0] tap_q, tap_d;
  sample_t         y_q, y_d, y_sat;
  logic            y_valid_q, y_valid_d;
  logic            sat_q, sat_d, sat_nxt;
  logic            ready_q;
  logic            accept, last_tap;

  // ready_q is held low through reset so nothing is taken before the first clock
  assign accept   = (state_q == ST_IDLE) && ready_q && bus.in_valid;
  assign last_tap = (tap_q == IDXW'(TAPS-1));

  mac_sequencer_sat_trunc u_sat (
    .x_i   (bus.mac_sum),
    .y_o   (y_sat),
    .sat_o (sat_nxt)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_d     = tap_q;
    y_d       = y_q;
    sat_d     = sat_q;
    y_valid_d = y_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          tap_d   = '0;
        end
      end
      ST_ACCUM: begin
        acc_d = bus.mac_sum;
        if (last_tap) begin
          state_d   = ST_OUTPUT;
          tap_d     = '0;
          y_d       = y_sat;
          sat_d     = sat_nxt;
          y_valid_d = 1'b1;
        end else begin
          tap_d = tap_q + IDXW'(1);
        end
      end
      ST_OUTPUT: begin
        if (bus.y_ready) begin
          state_d   = ST_IDLE;
          y_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      tap_q     <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      y_valid_q <= 1'b0;
      ready_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) delay_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_q     <= tap_d;
      y_q       <= y_d;
      sat_q     <= sat_d;
      y_valid_q <= y_valid_d;
      ready_q   <= (state_d == ST_IDLE);
      if (accept) begin
        delay_q[0] <= bus.x_in;
        for (int k = 1; k < TAPS; k++) delay_q[k] <= delay_q[k-1];
      end
    end
  end

  always_comb begin
    bus.coef_idx = '0;
    bus.mac_a    = '0;
    bus.mac_b    = '0;
    bus.mac_acc  = '0;
    if (state_q == ST_ACCUM) begin
      bus.coef_idx = tap_q;
      bus.mac_b    = bus.coef_in;
      bus.mac_acc  = acc_q;
      for (int k = 0; k < TAPS; k++)
        if (tap_q == IDXW'(k)) bus.mac_a = delay_q[k];
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.y_out    = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench: directed FIR scenarios plus random samples against a sum-of-products model.
module tb_mac_sequencer;
  import mac_sequencer_pkg::*;

  logic clk;
  logic reset_n;

  mac_sequencer_if bus ();

  mac_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  sample_t coef_tab [TAPS];
  longint  hist [TAPS];
  longint  exp_y;
  longint  exp_sat;
  int      n_checks = 0;
  int      n_errors = 0;

  // external coefficient table and multiply-add stage
  assign bus.coef_in = (int'(bus.coef_idx) < TAPS) ? coef_tab[bus.coef_idx] : '0;
  assign bus.mac_sum = wide_t'(bus.mac_a) * wide_t'(bus.mac_b) + bus.mac_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap2n(input longint v);
    return (v <<< (64 - 2*N)) >>> (64 - 2*N);
  endfunction

  function automatic void predict();
    longint s = 0;
    longint hi = (longint'(1) <<< (N-1)) - 1;
    longint lo = -(longint'(1) <<< (N-1));
    for (int k = 0; k < TAPS; k++) s += hist[k] * longint'(coef_tab[k]);
    s = wrap2n(s) >>> F;
    if (s > hi)      begin exp_y = hi; exp_sat = 1; end
    else if (s < lo) begin exp_y = lo; exp_sat = 1; end
    else             begin exp_y = s;  exp_sat = 0; end
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_hist();
  endtask

  // Called #1 after a clock edge; returns #1 after the edge where y_valid should rise.
  task automatic feed(input sample_t x);
    int     guard = 0;
    longint part  = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'(x);
    predict();
    for (int k = 0; k < TAPS; k++) begin
      chk("coef_idx", longint'(bus.coef_idx), k);
      chk("mac_a", longint'(bus.mac_a), hist[k]);
      chk("mac_acc", longint'(bus.mac_acc), part);
      if (k == 0) begin
        chk("in_ready_busy", longint'(bus.in_ready), 0);
        chk("y_valid_busy", longint'(bus.y_valid), 0);
      end
      part = wrap2n(part + hist[k] * longint'(coef_tab[k]));
      @(posedge clk); #1;
    end
    chk("y_valid_rise", longint'(bus.y_valid), 1);
    chk("y_out", longint'(bus.y_out), exp_y);
    chk("sat_flag", longint'(bus.sat_flag), exp_sat);
  endtask

  task automatic drain();
    bus.y_ready = 1'b1;
    @(posedge clk); #1;
    chk("y_valid_drop", longint'(bus.y_valid), 0);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
    coef_tab[0] = sample_t'(c0);
    coef_tab[1] = sample_t'(c1);
    coef_tab[2] = sample_t'(c2);
    coef_tab[3] = sample_t'(c3);
    coef_tab[4] = sample_t'(c4);
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b1;
    bus.x_in     = sample_t'(123);
    bus.y_ready  = 1'b1;
    set_coefs(0, 0, 0, 0, 0);
    clear_hist();

    // reset held with in_valid high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_y_valid", longint'(bus.y_valid), 0);
    chk("rst_y_out", longint'(bus.y_out), 0);
    chk("rst_sat", longint'(bus.sat_flag), 0);
    chk("rst_mac_a", longint'(bus.mac_a), 0);
    chk("rst_mac_acc", longint'(bus.mac_acc), 0);
    chk("rst_coef_idx", longint'(bus.coef_idx), 0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", longint'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("rel_in_ready", longint'(bus.in_ready), 1);
    chk("rel_no_accept", longint'(bus.mac_acc), 0);
    bus.in_valid = 1'b0;

    // impulse
    set_coefs(1024, 0, 0, 0, 0);
    feed(sample_t'(3072));
    chk("impulse_y", longint'(bus.y_out), 3072);
    drain();

    // moving average, fifth output
    set_coefs(205, 205, 205, 205, 205);
    for (int i = 0; i < 5; i++) begin
      feed(sample_t'(1024));
      drain();
    end
    chk("avg_y", longint'(bus.y_out), 1025);

    // negative floor
    do_reset();
    set_coefs(512, 0, 0, 0, 0);
    feed(sample_t'(-1));
    chk("floor_y", longint'(bus.y_out), -1);
    drain();

    // saturation both ways
    do_reset();
    set_coefs(1024, 1024, 0, 0, 0);
    feed(sample_t'(16777215));
    drain();
    feed(sample_t'(16777215));
    chk("satp_y", longint'(bus.y_out), 16777215);
    chk("satp_flag", longint'(bus.sat_flag), 1);
    drain();
    set_coefs(2048, 0, 0, 0, 0);
    feed(sample_t'(-16777216));
    chk("satn_y", longint'(bus.y_out), -16777216);
    chk("satn_flag", longint'(bus.sat_flag), 1);
    drain();

    // backpressure with in_valid toggling
    set_coefs(300, -700, 1100, 50, -9);
    bus.y_ready = 1'b0;
    feed(sample_t'(40000));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom);
      bus.x_in     = sample_t'($urandom);
      @(posedge clk); #1;
      chk("bp_y_valid", longint'(bus.y_valid), 1);
      chk("bp_y_out", longint'(bus.y_out), exp_y);
      chk("bp_sat", longint'(bus.sat_flag), exp_sat);
      chk("bp_in_ready", longint'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    drain();
    feed(sample_t'(-12345));
    drain();

    // asynchronous reset during tap 2, then impulse again
    set_coefs(1024, 0, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.x_in     = sample_t'(777);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_tap2", longint'(bus.coef_idx), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_mac_a", longint'(bus.mac_a), 0);
    chk("mid_mac_acc", longint'(bus.mac_acc), 0);
    chk("mid_coef_idx", longint'(bus.coef_idx), 0);
    chk("mid_in_ready", longint'(bus.in_ready), 0);
    chk("mid_y_valid", longint'(bus.y_valid), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_hist();
    feed(sample_t'(3072));
    chk("post_rst_impulse", longint'(bus.y_out), 3072);
    drain();

    // random samples, coefficients and stalls
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < TAPS; k++)
        coef_tab[k] = (i % 2 == 0) ? sample_t'($urandom)
                                   : sample_t'(int'($urandom_range(0, 8191)) - 4096);
      bus.y_ready = 1'b0;
      if (i % 3 == 0) feed(sample_t'($urandom));
      else            feed(sample_t'(int'($urandom_range(0, 2000000)) - 1000000));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold_y", longint'(bus.y_out), exp_y);
        chk("rnd_hold_v", longint'(bus.y_valid), 1);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
